// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg
// Shared definitions for the instruction-memory load controller and the
// fetch stage: session FSM state encoding, default load base address
// (also the core's reset PC) and largest legal session length.
// Ports: none (package).
package imem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0020;
   localparam int unsigned IMEM_MAX_WORDS = 32'd1024;

   // A session length is usable when it is non-zero and fits the memory window.
   function automatic logic len_is_legal(input logic [31:0] len,
                                         input int unsigned max_words);
      return (len != 32'd0) && (len <= max_words);
   endfunction

endpackage

// File: rtl/imem_addr_gen.sv
// imem_addr_gen
// Word counter for a load session plus the write-address adder.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : zero the counter (session start)
//   inc          : advance the counter by one word (accepted handshake)
//   count        : words accepted so far in this session
//   addr         : BASE_ADDR + count, wrapping modulo 2^ADDR_W
module imem_addr_gen #(
   parameter int                ADDR_W    = 32,
   parameter int                LEN_W     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [LEN_W-1:0]  count,
   output logic [ADDR_W-1:0] addr
);

   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] count_d;

   // Next counter value; clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {LEN_W{1'b0}};
      end else if (inc) begin
         count_d = count_q + LEN_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {LEN_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   // Word addressing: the counter is zero-extended and the sum wraps naturally.
   assign addr  = BASE_ADDR + ADDR_W'(count_q);

endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
// Owns the instruction-memory write port and the fetch-stall / PC-load path.
// A session writes load_len words from the ld_* stream to consecutive
// addresses from BASE_ADDR, then pulses pc_load to BASE_ADDR and releases
// fetch.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   load_start, load_len         : session request and its word count
//   ld_valid, ld_data, ld_ready  : loader word stream
//   mem_we, mem_waddr, mem_wdata : registered instruction-memory write port
//   fetch_stall                  : freeze PC/fetch until a load has completed
//   pc_load, pc_load_val         : one-cycle PC overwrite to BASE_ADDR
//   busy, done, err              : session status
module imem_load_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(IMEM_BASE_ADDR),
   parameter int unsigned       MAX_WORDS = IMEM_MAX_WORDS,
   parameter int                LEN_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              fetch_stall,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_load_val,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e              state_q,     state_d;
   logic [LEN_W-1:0]    len_q,       len_d;
   logic                loaded_q,    loaded_d;
   logic                done_q,      done_d;
   logic                err_q,       err_d;
   logic                ld_ready_q,  ld_ready_d;
   logic                busy_q,      busy_d;
   logic                stall_q,     stall_d;
   logic                pc_load_q,   pc_load_d;
   logic                mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic                hs_s;
   logic                last_s;
   logic                cnt_clr_s;
   logic                cnt_inc_s;
   logic [LEN_W-1:0]    cnt_s;
   logic [ADDR_W-1:0]   addr_s;

   imem_addr_gen #(
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_gen (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr_s),
      .inc   (cnt_inc_s),
      .count (cnt_s),
      .addr  (addr_s)
   );

   assign hs_s   = ld_valid & ld_ready_q;
   assign last_s = ((cnt_s + LEN_W'(1)) == len_q);

   // Session FSM next state, write-register capture and status flags.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      loaded_d    = loaded_q;
      done_d      = done_q;
      err_d       = err_q;
      mem_we_d    = 1'b0;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_clr_s   = 1'b0;
      cnt_inc_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               done_d = 1'b0;
               if (len_is_legal(32'(load_len), MAX_WORDS)) begin
                  state_d   = ST_LOAD;
                  len_d     = load_len;
                  err_d     = 1'b0;
                  cnt_clr_s = 1'b1;
               end else begin
                  // Rejected request: loaded and fetch_stall stay as they are.
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (hs_s) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = addr_s;
               mem_wdata_d = ld_data;
               cnt_inc_s   = 1'b1;
               if (last_s) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_FLUSH: begin
            // The last captured word is on the write port during this cycle.
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            state_d  = ST_IDLE;
            loaded_d = 1'b1;
            done_d   = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Outputs are decoded from the next state so they are registered.
      ld_ready_d = (state_d == ST_LOAD);
      busy_d     = (state_d != ST_IDLE);
      stall_d    = ~loaded_d | busy_d;
      pc_load_d  = (state_d == ST_RELEASE);
   end

   // State, status and write-port registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         len_q       <= {LEN_W{1'b0}};
         loaded_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ld_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         stall_q     <= 1'b1;
         pc_load_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         loaded_q    <= loaded_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ld_ready_q  <= ld_ready_d;
         busy_q      <= busy_d;
         stall_q     <= stall_d;
         pc_load_q   <= pc_load_d;
         mem_we_q    <= mem_we_d;
         mem_waddr_q <= mem_waddr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign ld_ready    = ld_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_wdata   = mem_wdata_q;
   assign fetch_stall = stall_q;
   assign pc_load     = pc_load_q;
   assign pc_load_val = BASE_ADDR;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl
// Drives load sessions into imem_load_ctrl (default base) and a second
// instance with base 32'hFFFF_FFFE sharing the same inputs. Written words
// are collected from the write port and compared with the session's
// expected image: word i of a session lands at base + i.
module tb_imem_load_ctrl;

   localparam logic [31:0] BASE   = 32'h0000_0020;
   localparam logic [31:0] BASE_W = 32'hFFFF_FFFE;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [15:0] load_len;
   logic        ld_valid;
   logic [15:0] ld_data;

   logic        ld_ready, mem_we, fetch_stall, pc_load, busy, done, err;
   logic [31:0] mem_waddr, pc_load_val;
   logic [15:0] mem_wdata;

   logic        ld_ready_w, mem_we_w, fetch_stall_w, pc_load_w, busy_w, done_w, err_w;
   logic [31:0] mem_waddr_w, pc_load_val_w;
   logic [15:0] mem_wdata_w;

   imem_load_ctrl dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .fetch_stall(fetch_stall), .pc_load(pc_load), .pc_load_val(pc_load_val),
      .busy(busy), .done(done), .err(err)
   );

   imem_load_ctrl #(.BASE_ADDR(BASE_W)) dut_w (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_w),
      .mem_we(mem_we_w), .mem_waddr(mem_waddr_w), .mem_wdata(mem_wdata_w),
      .fetch_stall(fetch_stall_w), .pc_load(pc_load_w), .pc_load_val(pc_load_val_w),
      .busy(busy_w), .done(done_w), .err(err_w)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Write-port monitor: everything committed at a rising edge is logged.
   int          cyc = 0;
   int          pcl = 0;
   logic [31:0] wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   logic [31:0] wa2[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) begin
         wa.push_back(mem_waddr);
         wd.push_back(mem_wdata);
         wc.push_back(cyc);
      end
      if (mem_we_w) wa2.push_back(mem_waddr_w);
      if (pc_load) pcl <= pcl + 1;
   end

   // Expected image for the current session.
   logic [15:0] words[$];

   typedef struct {
      int          sent;
      logic        rdy0, rdy1, we1, pcl1, pcl2, done3, stall3, busy3;
      logic [31:0] pcv2;
   } obs_t;

   // Starts a session of n words and streams words[] with a valid pattern:
   // mode 0 back-to-back, 1 toggling 1,0,0,..., 2 random. restart_at pulses
   // load_start on that stream cycle. Samples the tail k+1..k+3.
   task automatic do_session(input int n, input int mode, input int restart_at, output obs_t o);
      int k;
      logic v;
      o.sent = 0;
      @(negedge clk);
      load_start = 1'b1;
      load_len   = 16'(n);
      @(negedge clk);
      load_start = 1'b0;
      load_len   = 16'($urandom);
      o.rdy0     = ld_ready;
      k = 0;
      while (1) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = ((k % 3) == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         load_start = (k == restart_at);
         if (k == restart_at) load_len = 16'd3;
         ld_valid = v;
         ld_data  = v ? words[o.sent] : 16'($urandom);
         if (v && ld_ready) o.sent++;
         if (o.sent == n || k > 5000) break;
         k++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      load_start = 1'b0;
      ld_valid   = 1'b1;          // keep offering a word the controller must refuse
      ld_data    = 16'hDEAD;
      @(negedge clk);
      o.rdy1 = ld_ready; o.we1 = mem_we; o.pcl1 = pc_load;
      @(negedge clk);
      o.pcl2 = pc_load; o.pcv2 = pc_load_val;
      @(negedge clk);
      o.done3 = done; o.stall3 = fetch_stall; o.busy3 = busy;
      ld_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; load_start = 1'b0; load_len = 16'd0; ld_valid = 1'b0; ld_data = 16'd0;
      repeat (3) @(negedge clk);
      total++;
      if ({ld_ready, mem_we, fetch_stall, pc_load, busy, done, err} !== 7'b0010000) begin
         bad++; $display("FAIL reset_flags: got %b want 0010000",
                         {ld_ready, mem_we, fetch_stall, pc_load, busy, done, err});
      end
      total++;
      if ({mem_waddr, mem_wdata} !== 48'd0) begin
         bad++; $display("FAIL reset_wport: got %h want 0", {mem_waddr, mem_wdata});
      end
      total++;
      if (pc_load_val !== BASE) begin
         bad++; $display("FAIL reset_pcval: got %h want %h", pc_load_val, BASE);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, fetch_stall} !== 2'b01) begin
         bad++; $display("FAIL after_reset: busy/stall got %b want 01", {busy, fetch_stall});
      end
   endtask

   task automatic test_illegal();
      int b;
      logic [15:0] lens [2];
      lens[0] = 16'd0; lens[1] = 16'd1025;
      b = wa.size();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         load_start = 1'b1; load_len = lens[i];
         @(negedge clk);
         load_start = 1'b0;
         total++;
         if ({err, busy, ld_ready, fetch_stall, done} !== 5'b10010) begin
            bad++; $display("FAIL illegal_len_%0d: err/busy/rdy/stall/done got %b want 10010",
                            lens[i], {err, busy, ld_ready, fetch_stall, done});
         end
      end
      repeat (3) @(negedge clk);
      total++;
      if (wa.size() - b != 0) begin
         bad++; $display("FAIL illegal_writes: got %0d want 0", wa.size() - b);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      int b, p0;
      logic [15:0] rd;
      words.delete();
      for (int i = 0; i < 6; i++) words.push_back(16'h0070 + 16'(i));
      b = wa.size(); p0 = pcl;
      do_session(6, 0, -1, o);
      total++;
      if (o.sent != 6 || o.rdy0 !== 1'b1) begin
         bad++; $display("FAIL b2b_stream: sent %0d rdy0 %b want 6 1", o.sent, o.rdy0);
      end
      total++;
      if (wa.size() - b != 6) begin
         bad++; $display("FAIL b2b_count: got %0d want 6", wa.size() - b);
      end
      for (int i = 0; i < 6 && b + i < wa.size(); i++) begin
         total++;
         if (wa[b+i] !== BASE + 32'(i) || wd[b+i] !== words[i]) begin
            bad++; $display("FAIL b2b_write%0d: got %h/%h want %h/%h",
                            i, wa[b+i], wd[b+i], BASE + 32'(i), words[i]);
         end
         if (i > 0) begin
            total++;
            if (wc[b+i] - wc[b+i-1] != 1) begin
               bad++; $display("FAIL b2b_spacing%0d: got %0d want 1", i, wc[b+i] - wc[b+i-1]);
            end
         end
      end
      total++;
      if ({o.we1, o.pcl1, o.pcl2} !== 3'b101 || o.pcv2 !== BASE) begin
         bad++; $display("FAIL b2b_tail: we1/pcl1/pcl2 %b pcv %h want 101 %h",
                         {o.we1, o.pcl1, o.pcl2}, o.pcv2, BASE);
      end
      total++;
      if ({o.done3, o.stall3, o.busy3, err} !== 4'b1000) begin
         bad++; $display("FAIL b2b_release: done/stall/busy/err got %b want 1000",
                         {o.done3, o.stall3, o.busy3, err});
      end
      total++;
      if (pcl - p0 != 1) begin
         bad++; $display("FAIL b2b_pcload_count: got %0d want 1", pcl - p0);
      end
      rd = 16'hxxxx;
      for (int i = b; i < wa.size(); i++) if (wa[i] == o.pcv2) rd = wd[i];
      total++;
      if (rd !== 16'h0070) begin
         bad++; $display("FAIL fetch_first_word: got %h want 0070", rd);
      end
   endtask

   task automatic test_gaps();
      obs_t o;
      int b;
      words.delete();
      for (int i = 0; i < 6; i++) words.push_back(16'h0070 + 16'(i));
      b = wa.size();
      do_session(6, 1, -1, o);
      total++;
      if (o.rdy1 !== 1'b0) begin
         bad++; $display("FAIL gaps_ready_drop: got %b want 0", o.rdy1);
      end
      total++;
      if (wa.size() - b != 6) begin
         bad++; $display("FAIL gaps_count: got %0d want 6", wa.size() - b);
      end
      for (int i = 0; i < 6 && b + i < wa.size(); i++) begin
         total++;
         if (wa[b+i] !== BASE + 32'(i) || wd[b+i] !== words[i]) begin
            bad++; $display("FAIL gaps_write%0d: got %h/%h want %h/%h",
                            i, wa[b+i], wd[b+i], BASE + 32'(i), words[i]);
         end
      end
   endtask

   task automatic test_restart_ignored();
      obs_t o;
      int b, p0;
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(16'($urandom));
      b = wa.size(); p0 = pcl;
      do_session(4, 0, 2, o);
      repeat (6) @(negedge clk);
      total++;
      if (wa.size() - b != 4 || pcl - p0 != 1) begin
         bad++; $display("FAIL restart_ignored: writes %0d pc_loads %0d want 4 1",
                         wa.size() - b, pcl - p0);
      end
      total++;
      if ({busy, done} !== 2'b01) begin
         bad++; $display("FAIL restart_idle: busy/done got %b want 01", {busy, done});
      end
   endtask

   task automatic test_random();
      obs_t o;
      int b, p0, n;
      for (int s = 0; s < 6; s++) begin
         n = (s == 5) ? 1024 : ((s == 4) ? 1 : $urandom_range(1, 12));
         words.delete();
         for (int i = 0; i < n; i++) words.push_back(16'($urandom));
         b = wa.size(); p0 = pcl;
         do_session(n, (s == 5) ? 0 : 2, -1, o);
         total++;
         if (wa.size() - b != n || pcl - p0 != 1 || o.done3 !== 1'b1) begin
            bad++; $display("FAIL rand%0d_session: writes %0d pcl %0d done %b want %0d 1 1",
                            s, wa.size() - b, pcl - p0, o.done3, n);
         end
         for (int i = 0; i < n && b + i < wa.size(); i++) begin
            if (wa[b+i] !== BASE + 32'(i) || wd[b+i] !== words[i]) begin
               total++; bad++;
               $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h",
                        s, i, wa[b+i], wd[b+i], BASE + 32'(i), words[i]);
               break;
            end
         end
      end
      // A rejected request after a completed load keeps fetch running.
      @(negedge clk);
      load_start = 1'b1; load_len = 16'd0;
      @(negedge clk);
      load_start = 1'b0;
      total++;
      if ({err, done, fetch_stall, busy} !== 4'b1000) begin
         bad++; $display("FAIL reject_after_load: err/done/stall/busy got %b want 1000",
                         {err, done, fetch_stall, busy});
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int b, p0, sent;
      b = wa.size(); p0 = pcl;
      @(negedge clk);
      load_start = 1'b1; load_len = 16'd6;
      @(negedge clk);
      load_start = 1'b0;
      sent = 0;
      for (int k = 0; k < 50 && sent < 3; k++) begin
         ld_valid = 1'b1; ld_data = 16'hA000 + 16'(sent);
         if (ld_ready) sent++;
         if (sent < 3) @(negedge clk);
      end
      @(posedge clk);
      #1 ld_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if ({ld_ready, mem_we, fetch_stall, pc_load, busy, done, err} !== 7'b0010000 ||
          {mem_waddr, mem_wdata} !== 48'd0) begin
         bad++; $display("FAIL async_reset: flags %b wport %h want 0010000 0",
                         {ld_ready, mem_we, fetch_stall, pc_load, busy, done, err},
                         {mem_waddr, mem_wdata});
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (wa.size() - b != 3 || pcl - p0 != 0) begin
         bad++; $display("FAIL reset_mid_effects: writes %0d pcl %0d want 3 0",
                         wa.size() - b, pcl - p0);
      end
      words.delete();
      words.push_back(16'h1234); words.push_back(16'h5678);
      b = wa.size(); p0 = pcl;
      do_session(2, 0, -1, o);
      total++;
      if (wa.size() - b != 2 || pcl - p0 != 1 || {o.done3, o.stall3} !== 2'b10) begin
         bad++; $display("FAIL reload_2: writes %0d pcl %0d done/stall %b want 2 1 10",
                         wa.size() - b, pcl - p0, {o.done3, o.stall3});
      end
      for (int i = 0; i < 2 && b + i < wa.size(); i++) begin
         total++;
         if (wa[b+i] !== BASE + 32'(i) || wd[b+i] !== words[i]) begin
            bad++; $display("FAIL reload_write%0d: got %h/%h want %h/%h",
                            i, wa[b+i], wd[b+i], BASE + 32'(i), words[i]);
         end
      end
   endtask

   task automatic test_wrap();
      obs_t o;
      int b;
      logic [31:0] exp_a;
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(16'($urandom));
      b = wa2.size();
      do_session(4, 0, -1, o);
      total++;
      if (wa2.size() - b != 4) begin
         bad++; $display("FAIL wrap_count: got %0d want 4", wa2.size() - b);
      end
      for (int i = 0; i < 4 && b + i < wa2.size(); i++) begin
         exp_a = BASE_W + 32'(i);
         total++;
         if (wa2[b+i] !== exp_a) begin
            bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, wa2[b+i], exp_a);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_illegal();
      test_back_to_back();
      test_gaps();
      test_restart_ignored();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
